// File: rtl/conv_positioner_pkg.sv
// -----------------------------------------------------------------------------
// conv_positioner_pkg
// Shared definitions for the convolution window positioner and the writeback
// address generator: position-FSM state encodings, the output-map dimension
// helper, and the output-map size for the default image/kernel configuration.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef CONV_POSITIONER_DEFS
`define CONV_POSITIONER_DEFS
`define POS_IDLE       2'd0
`define POS_STREAM     2'd1
`define POS_ROUND_DONE 2'd2
`endif

package conv_positioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = `POS_IDLE,
    ST_STREAM     = `POS_STREAM,
    ST_ROUND_DONE = `POS_ROUND_DONE
  } pos_state_t;

  // Number of window positions along one image dimension.
  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

  localparam int DFLT_IMG_W  = 8;
  localparam int DFLT_IMG_H  = 8;
  localparam int DFLT_KERNEL = 3;
  localparam int DFLT_STRIDE = 1;

  localparam int OUT_W = out_dim(DFLT_IMG_W, DFLT_KERNEL, DFLT_STRIDE);
  localparam int OUT_H = out_dim(DFLT_IMG_H, DFLT_KERNEL, DFLT_STRIDE);

endpackage

// File: rtl/conv_positioner_if.sv
// -----------------------------------------------------------------------------
// conv_positioner_if
// Bundle between the positioner (master) and the image broadcaster (slave):
//   addr / addr_valid / addr_ready : window read-address stream
//   pos_x / pos_y                  : top-left pixel of the current window
//   round / done                   : window exhausted / last window exhausted
// -----------------------------------------------------------------------------
interface conv_positioner_if #(
  parameter int ADDR_W = 16,
  parameter int POS_W  = 8
);
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic [POS_W-1:0]  pos_x;
  logic [POS_W-1:0]  pos_y;
  logic              round;
  logic              done;

  modport master (
    output addr, addr_valid, pos_x, pos_y, round, done,
    input  addr_ready
  );

  modport slave (
    input  addr, addr_valid, pos_x, pos_y, round, done,
    output addr_ready
  );
endinterface

// File: rtl/conv_positioner_window_counter.sv
// -----------------------------------------------------------------------------
// window_counter
// Walks the K x K window of one position: kx innermost, ky outer. The address
// is built incrementally (+1 along a row, row_base + IMG_W at row wrap), so the
// per-beat path has adders only.
//   clk, rst    : clock, async active-high reset
//   clear       : synchronous clear (highest priority after rst)
//   load        : start a new window at start_addr
//   start_addr  : address of the window's top-left pixel
//   step        : handshake accepted this cycle, advance to next beat
//   addr        : current beat address (registered)
//   last_beat   : current beat is (K-1, K-1)
// -----------------------------------------------------------------------------
module window_counter
  import conv_positioner_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int KERNEL = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last_beat
);

  localparam int KC_W = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam logic [KC_W-1:0]   K_LAST   = KC_W'(KERNEL - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [KC_W-1:0]   kx;
  logic [KC_W-1:0]   ky;
  logic [ADDR_W-1:0] row_base;

  assign last_beat = (kx == K_LAST) && (ky == K_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx       <= '0;
      ky       <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (clear) begin
      kx       <= '0;
      ky       <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (load) begin
      kx       <= '0;
      ky       <= '0;
      row_base <= start_addr;
      addr     <= start_addr;
    end else if (step) begin
      if (kx == K_LAST) begin
        // Row wrap; ky overrunning after the last beat is harmless, the
        // next load reinitialises it.
        kx       <= '0;
        ky       <= ky + 1'b1;
        row_base <= row_base + ROW_STEP;
        addr     <= row_base + ROW_STEP;
      end else begin
        kx   <= kx + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_positioner.sv
// -----------------------------------------------------------------------------
// conv_positioner
// Steps the convolution window across the image in row-major, stride-aware
// order, one position per accepted advance, and streams the K*K read addresses
// of each window over a valid/ready handshake.
//   clk      : clock, rising edge
//   rst      : async active-high reset
//   restart  : synchronous clear to IDLE (wins over advance)
//   advance  : one-cycle request to step to the next position
//   bus      : master side of conv_positioner_if (addr stream, position,
//              round/done levels)
// -----------------------------------------------------------------------------
module conv_positioner
  import conv_positioner_pkg::*;
#(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int KERNEL    = 3,
  parameter int STRIDE    = 1,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 16,
  parameter int POS_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              advance,
  conv_positioner_if.master bus
);

  localparam int POS_CNT_X = out_dim(IMG_W, KERNEL, STRIDE);
  localparam int POS_CNT_Y = out_dim(IMG_H, KERNEL, STRIDE);
  // Last reachable top-left coordinates; stepping past them wraps/terminates.
  localparam logic [POS_W-1:0] X_LAST   = POS_W'((POS_CNT_X - 1) * STRIDE);
  localparam logic [POS_W-1:0] Y_LAST   = POS_W'((POS_CNT_Y - 1) * STRIDE);
  localparam logic [POS_W-1:0] POS_STEP = POS_W'(STRIDE);

  pos_state_t        state;
  pos_state_t        state_nxt;
  logic [POS_W-1:0]  pos_x;
  logic [POS_W-1:0]  pos_y;
  logic [POS_W-1:0]  pos_x_nxt;
  logic [POS_W-1:0]  pos_y_nxt;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] win_addr;
  logic              accept;
  logic              hs;
  logic              last_beat;
  logic              is_last;

  assign is_last = (pos_x == X_LAST) && (pos_y == Y_LAST);
  assign hs      = (state == ST_STREAM) && bus.addr_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (restart) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (advance) begin
            accept    = 1'b1;
            state_nxt = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (hs && last_beat) state_nxt = ST_ROUND_DONE;
        end
        ST_ROUND_DONE: begin
          if (advance && !is_last) begin
            accept    = 1'b1;
            state_nxt = ST_STREAM;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next position: (0,0) from IDLE, otherwise one stride step with row wrap.
  always_comb begin
    pos_x_nxt = '0;
    pos_y_nxt = '0;
    if (state == ST_ROUND_DONE) begin
      if (pos_x == X_LAST) begin
        pos_y_nxt = pos_y + POS_STEP;
      end else begin
        pos_x_nxt = pos_x + POS_STEP;
        pos_y_nxt = pos_y;
      end
    end
  end

  // Window origin: multiplier sits on the once-per-round load, not the beat path.
  assign start_addr = ADDR_W'(BASE_ADDR)
                    + ADDR_W'(pos_y_nxt) * ADDR_W'(IMG_W)
                    + ADDR_W'(pos_x_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (restart) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (accept) begin
      pos_x <= pos_x_nxt;
      pos_y <= pos_y_nxt;
    end
  end

  window_counter #(
    .IMG_W  (IMG_W),
    .KERNEL (KERNEL),
    .ADDR_W (ADDR_W)
  ) u_window_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .load       (accept),
    .start_addr (start_addr),
    .step       (hs),
    .addr       (win_addr),
    .last_beat  (last_beat)
  );

  // Output decode (all terms come straight from registers)
  always_comb begin
    bus.addr       = win_addr;
    bus.addr_valid = (state == ST_STREAM);
    bus.pos_x      = pos_x;
    bus.pos_y      = pos_y;
    bus.round      = (state == ST_ROUND_DONE);
    bus.done       = (state == ST_ROUND_DONE) && is_last;
  end

endmodule

// File: tb/tb_conv_positioner.sv
module tb_conv_positioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic restart_a, advance_a;
  logic restart_b, advance_b;

  int checks = 0;
  int errors = 0;

  conv_positioner_if #(.ADDR_W(16), .POS_W(8)) bus_a ();
  conv_positioner_if #(.ADDR_W(16), .POS_W(8)) bus_b ();

  conv_positioner #(
    .IMG_W(4), .IMG_H(4), .KERNEL(3), .STRIDE(1),
    .BASE_ADDR(0), .ADDR_W(16), .POS_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .restart(restart_a), .advance(advance_a),
    .bus(bus_a.master)
  );

  conv_positioner #(
    .IMG_W(8), .IMG_H(8), .KERNEL(3), .STRIDE(2),
    .BASE_ADDR(100), .ADDR_W(16), .POS_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .restart(restart_b), .advance(advance_b),
    .bus(bus_b.master)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    restart_a = 1'b0; advance_a = 1'b0;
    restart_b = 1'b0; advance_b = 1'b0;
    bus_a.addr_ready = 1'b1;
    bus_b.addr_ready = 1'b1;
    tick; tick;
    checks++;
    if ({bus_a.addr, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y, bus_a.round, bus_a.done} !== 38'd0) begin
      errors++;
      $display("FAIL reset_a addr=%0d valid=%b pos=(%0d,%0d) round=%b done=%b expected all 0",
               bus_a.addr, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y, bus_a.round, bus_a.done);
    end
    checks++;
    if ({bus_b.addr, bus_b.addr_valid, bus_b.pos_x, bus_b.pos_y, bus_b.round, bus_b.done} !== 38'd0) begin
      errors++;
      $display("FAIL reset_b addr=%0d valid=%b pos=(%0d,%0d) round=%b done=%b expected all 0",
               bus_b.addr, bus_b.addr_valid, bus_b.pos_x, bus_b.pos_y, bus_b.round, bus_b.done);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_first_round;
    int exp_a[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    advance_a = 1'b1; tick; advance_a = 1'b0;
    checks++;
    if (bus_a.pos_x !== 8'd0 || bus_a.pos_y !== 8'd0 || bus_a.round !== 1'b0) begin
      errors++;
      $display("FAIL first_pos pos=(%0d,%0d) round=%b expected (0,0) round=0",
               bus_a.pos_x, bus_a.pos_y, bus_a.round);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus_a.addr_valid !== 1'b1 || bus_a.addr !== 16'(exp_a[i])) begin
        errors++;
        $display("FAIL first_addr[%0d] got %0d valid=%b expected %0d valid=1",
                 i, bus_a.addr, bus_a.addr_valid, exp_a[i]);
      end
      tick;
    end
    checks++;
    if ({bus_a.round, bus_a.done, bus_a.addr_valid} !== 3'b100) begin
      errors++;
      $display("FAIL first_round round=%b done=%b valid=%b expected 1 0 0",
               bus_a.round, bus_a.done, bus_a.addr_valid);
    end
  endtask

  // Includes an advance pulse mid-stream, which must be ignored.
  task automatic test_second_round;
    int exp_a[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    advance_a = 1'b1; tick; advance_a = 1'b0;
    checks++;
    if (bus_a.pos_x !== 8'd1 || bus_a.pos_y !== 8'd0 || bus_a.round !== 1'b0) begin
      errors++;
      $display("FAIL second_pos pos=(%0d,%0d) round=%b expected (1,0) round=0",
               bus_a.pos_x, bus_a.pos_y, bus_a.round);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus_a.addr_valid !== 1'b1 || bus_a.addr !== 16'(exp_a[i]) ||
          bus_a.pos_x !== 8'd1 || bus_a.pos_y !== 8'd0) begin
        errors++;
        $display("FAIL second_addr[%0d] got %0d valid=%b pos=(%0d,%0d) expected %0d valid=1 pos=(1,0)",
                 i, bus_a.addr, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y, exp_a[i]);
      end
      advance_a = (i == 4);
      tick;
      advance_a = 1'b0;
    end
    checks++;
    if ({bus_a.round, bus_a.done, bus_a.addr_valid} !== 3'b100) begin
      errors++;
      $display("FAIL second_round round=%b done=%b valid=%b expected 1 0 0",
               bus_a.round, bus_a.done, bus_a.addr_valid);
    end
  endtask

  task automatic test_third_round;
    int exp_a[9] = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
    advance_a = 1'b1; tick; advance_a = 1'b0;
    checks++;
    if (bus_a.pos_x !== 8'd0 || bus_a.pos_y !== 8'd1) begin
      errors++;
      $display("FAIL third_pos pos=(%0d,%0d) expected (0,1)", bus_a.pos_x, bus_a.pos_y);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus_a.addr_valid !== 1'b1 || bus_a.addr !== 16'(exp_a[i])) begin
        errors++;
        $display("FAIL third_addr[%0d] got %0d valid=%b expected %0d valid=1",
                 i, bus_a.addr, bus_a.addr_valid, exp_a[i]);
      end
      tick;
    end
    checks++;
    if ({bus_a.round, bus_a.done} !== 2'b10) begin
      errors++;
      $display("FAIL third_round round=%b done=%b expected 1 0", bus_a.round, bus_a.done);
    end
  endtask

  task automatic test_last_round;
    int exp_a[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    advance_a = 1'b1; tick; advance_a = 1'b0;
    checks++;
    if (bus_a.pos_x !== 8'd1 || bus_a.pos_y !== 8'd1 || bus_a.done !== 1'b0) begin
      errors++;
      $display("FAIL last_pos pos=(%0d,%0d) done=%b expected (1,1) done=0",
               bus_a.pos_x, bus_a.pos_y, bus_a.done);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus_a.addr_valid !== 1'b1 || bus_a.addr !== 16'(exp_a[i])) begin
        errors++;
        $display("FAIL last_addr[%0d] got %0d valid=%b expected %0d valid=1",
                 i, bus_a.addr, bus_a.addr_valid, exp_a[i]);
      end
      tick;
    end
    checks++;
    if ({bus_a.round, bus_a.done, bus_a.addr_valid} !== 3'b110) begin
      errors++;
      $display("FAIL last_round round=%b done=%b valid=%b expected 1 1 0",
               bus_a.round, bus_a.done, bus_a.addr_valid);
    end
  endtask

  task automatic test_done_hold;
    advance_a = 1'b1; tick; advance_a = 1'b0;
    tick; tick;
    checks++;
    if ({bus_a.round, bus_a.done, bus_a.addr_valid} !== 3'b110 ||
        bus_a.pos_x !== 8'd1 || bus_a.pos_y !== 8'd1) begin
      errors++;
      $display("FAIL done_hold round=%b done=%b valid=%b pos=(%0d,%0d) expected 1 1 0 (1,1)",
               bus_a.round, bus_a.done, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y);
    end
  endtask

  task automatic test_restart_midstream;
    restart_a = 1'b1; tick; restart_a = 1'b0;
    checks++;
    if ({bus_a.addr, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y, bus_a.round, bus_a.done} !== 38'd0) begin
      errors++;
      $display("FAIL restart_from_done addr=%0d valid=%b round=%b done=%b expected all 0",
               bus_a.addr, bus_a.addr_valid, bus_a.round, bus_a.done);
    end
    advance_a = 1'b1; tick; advance_a = 1'b0;
    tick; tick; tick;
    checks++;
    if (bus_a.addr !== 16'd4 || bus_a.addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre_addr got %0d valid=%b expected 4 valid=1",
               bus_a.addr, bus_a.addr_valid);
    end
    restart_a = 1'b1; advance_a = 1'b1; tick;
    restart_a = 1'b0; advance_a = 1'b0;
    checks++;
    if ({bus_a.addr, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y, bus_a.round, bus_a.done} !== 38'd0) begin
      errors++;
      $display("FAIL restart_with_advance addr=%0d valid=%b pos=(%0d,%0d) round=%b expected all 0",
               bus_a.addr, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y, bus_a.round);
    end
    tick;
    checks++;
    if (bus_a.addr_valid !== 1'b0 || bus_a.round !== 1'b0) begin
      errors++;
      $display("FAIL restart_stays_idle valid=%b round=%b expected 0 0",
               bus_a.addr_valid, bus_a.round);
    end
  endtask

  task automatic test_backpressure;
    int exp_a[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int idx = 0;
    int cyc = 0;
    advance_a = 1'b1; tick; advance_a = 1'b0;
    while (idx < 9 && cyc < 30) begin
      checks++;
      if (bus_a.addr_valid !== 1'b1 || bus_a.addr !== 16'(exp_a[idx])) begin
        errors++;
        $display("FAIL bp_addr cyc=%0d got %0d valid=%b expected %0d valid=1",
                 cyc, bus_a.addr, bus_a.addr_valid, exp_a[idx]);
      end
      bus_a.addr_ready = !(cyc >= 2 && cyc < 5);
      tick;
      if (bus_a.addr_ready) idx++;
      cyc++;
    end
    bus_a.addr_ready = 1'b1;
    checks++;
    if (cyc !== 12) begin
      errors++;
      $display("FAIL bp_latency cycles=%0d beats=%0d expected 12 cycles 9 beats", cyc, idx);
    end
    checks++;
    if ({bus_a.round, bus_a.addr_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_round round=%b valid=%b expected 1 0", bus_a.round, bus_a.addr_valid);
    end
  endtask

  task automatic test_rst_midstream;
    advance_a = 1'b1; tick; advance_a = 1'b0;
    checks++;
    if (bus_a.addr_valid !== 1'b1 || bus_a.pos_x !== 8'd1) begin
      errors++;
      $display("FAIL rst_pre_pos valid=%b pos_x=%0d expected 1 1", bus_a.addr_valid, bus_a.pos_x);
    end
    tick; tick; tick; tick;
    checks++;
    if (bus_a.addr !== 16'd6) begin
      errors++;
      $display("FAIL rst_pre_addr got %0d expected 6", bus_a.addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_a.addr, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y, bus_a.round, bus_a.done} !== 38'd0) begin
      errors++;
      $display("FAIL rst_async addr=%0d valid=%b pos=(%0d,%0d) round=%b expected all 0",
               bus_a.addr, bus_a.addr_valid, bus_a.pos_x, bus_a.pos_y, bus_a.round);
    end
    #2;
    rst = 1'b0;
    tick;
    advance_a = 1'b1; tick; advance_a = 1'b0;
    checks++;
    if (bus_a.pos_x !== 8'd0 || bus_a.pos_y !== 8'd0 || bus_a.addr !== 16'd0 || bus_a.addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_resume pos=(%0d,%0d) addr=%0d valid=%b expected (0,0) 0 1",
               bus_a.pos_x, bus_a.pos_y, bus_a.addr, bus_a.addr_valid);
    end
  endtask

  task automatic test_stride;
    int ex[9] = '{0, 2, 4, 0, 2, 4, 0, 2, 4};
    int ey[9] = '{0, 0, 0, 2, 2, 2, 4, 4, 4};
    int ea[9] = '{100, 102, 104, 116, 118, 120, 132, 134, 136};
    for (int r = 0; r < 9; r++) begin
      int cyc = 0;
      advance_b = 1'b1; tick; advance_b = 1'b0;
      checks++;
      if (bus_b.pos_x !== 8'(ex[r]) || bus_b.pos_y !== 8'(ey[r]) ||
          bus_b.addr !== 16'(ea[r]) || bus_b.addr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stride_start[%0d] pos=(%0d,%0d) addr=%0d valid=%b expected (%0d,%0d) %0d 1",
                 r, bus_b.pos_x, bus_b.pos_y, bus_b.addr, bus_b.addr_valid, ex[r], ey[r], ea[r]);
      end
      while (bus_b.round !== 1'b1 && cyc < 20) begin
        tick;
        cyc++;
      end
      checks++;
      if (cyc !== 9) begin
        errors++;
        $display("FAIL stride_latency[%0d] cycles=%0d expected 9", r, cyc);
      end
      checks++;
      if (bus_b.done !== (r == 8)) begin
        errors++;
        $display("FAIL stride_done[%0d] done=%b expected %0d", r, bus_b.done, (r == 8));
      end
    end
    advance_b = 1'b1; tick; advance_b = 1'b0;
    tick;
    checks++;
    if ({bus_b.round, bus_b.done, bus_b.addr_valid} !== 3'b110 ||
        bus_b.pos_x !== 8'd4 || bus_b.pos_y !== 8'd4) begin
      errors++;
      $display("FAIL stride_hold round=%b done=%b valid=%b pos=(%0d,%0d) expected 1 1 0 (4,4)",
               bus_b.round, bus_b.done, bus_b.addr_valid, bus_b.pos_x, bus_b.pos_y);
    end
  endtask

  initial begin
    test_reset;
    test_first_round;
    test_second_round;
    test_third_round;
    test_last_round;
    test_done_hold;
    test_restart_midstream;
    test_backpressure;
    test_rst_midstream;
    test_stride;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
